// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I fetch types, widths and PC helper
package rv32i_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush and registered storage
// Head reads only from storage registers, so there is no path from push data to head.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_i && !do_pop) assert (count_q != CW'(DEPTH));
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, credit-limited requests, response pairing, decode FIFO
// Define FETCH_PERF_EN to add the perf_fetched/perf_dropped saturating counters.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   count;
  logic [CW+1:0]   inflight;
  logic            req_fire, resp_take, resp_drop, resp_any, out_fire;
  fetch_entry_t    pcq_push, pcq_head, fifo_push, fifo_head;

  // Dropped responses still occupy memory-side credit until they come back.
  assign inflight       = (CW+2)'(outstanding) + (CW+2)'(drop_q) + (CW+2)'(count);
  assign imem_req_valid = !rst && !redirect_valid && (inflight < (CW+2)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_q != '0);
  assign resp_take = imem_resp_valid && (drop_q == '0) && (outstanding != '0);
  assign resp_any  = resp_drop || resp_take;

  assign out_valid = !rst && (count != '0);
  assign out_fire  = out_valid && out_ready;
  assign out_pc    = out_valid ? fifo_head.pc : '0;
  assign out_instr = out_valid ? fifo_head.instr : '0;

  assign pcq_push  = '{pc: pc_q, instr: NOP_INSTR};
  assign fifo_push = '{pc: pcq_head.pc, instr: imem_resp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (req_fire),
    .push_data_i (pcq_push),
    .pop_i       (resp_take),
    .head_o      (pcq_head),
    .count_o     (outstanding)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (resp_take),
    .push_data_i (fifo_push),
    .pop_i       (out_fire),
    .head_o      (fifo_head),
    .count_o     (count)
  );

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~XLEN'(3);
      drop_d = drop_q + outstanding - CW'(resp_any);
    end else begin
      if (req_fire) pc_d = pc_next(pc_q);
      drop_d = drop_q - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && resp_take) assert (pcq_head.instr == NOP_INSTR);
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q;
  logic [31:0] fetched_inc, dropped_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // A redirect discards every buffered entry plus any response landing that cycle.
  assign fetched_inc = 32'(out_fire && !redirect_valid);
  assign dropped_inc = redirect_valid ? (32'(count) + 32'(resp_any)) : 32'(resp_drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= sat_add(perf_fetched_q, fetched_inc);
      perf_dropped_q <= sat_add(perf_dropped_q, dropped_inc);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a stream-level model
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic        redirect_valid, out_valid, out_ready;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, out_instr, out_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
  );

  always #5 clk = ~clk;

  // Memory requests tagged with the fetch epoch they were issued in.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t       memq[$];
  int          last_due, epoch, buffered, cyc;
  logic [31:0] exp_req, exp_out;
  int          rdy_pct, ordy_pct, lat_min, lat_max;
  int          n_checks, n_pass;
  logic        s_req_valid, s_acc, s_out_valid, s_pop;
  logic [31:0] s_req_addr, s_out_pc;
  int          first, n_acc, found, r;
  logic [31:0] acc_addr [3];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_0F13;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step(input logic do_rst, input logic do_redir, input logic [31:0] rpc);
    logic  resp_now;
    logic  exp_rv;
    mreq_t m;
    int    lat, due;
    rst            = do_rst;
    redirect_valid = do_redir;
    redirect_pc    = rpc;
    imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
    out_ready      = (int'($urandom_range(99)) < ordy_pct);
    resp_now       = !do_rst && (memq.size() > 0) && (memq[0].due <= cyc);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? mem_word(memq[0].addr) : $urandom();
    #1;
    exp_rv = !do_rst && !do_redir && ((memq.size() + buffered) < DEPTH);
    check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (do_rst) begin
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_pc", out_pc, 32'd0);
      check_eq("rst_out_instr", out_instr, 32'd0);
    end else begin
      check_eq("out_valid", 32'(out_valid), 32'(buffered > 0));
      if (out_valid && buffered > 0) begin
        check_eq("out_pc", out_pc, exp_out);
        check_eq("out_instr", out_instr, mem_word(exp_out));
      end
      if (imem_req_valid && exp_rv) check_eq("req_addr", imem_req_addr, exp_req);
    end
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_acc       = !do_rst && !do_redir && imem_req_valid && imem_req_ready;
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    s_pop       = !do_rst && !do_redir && out_valid && out_ready && (buffered > 0);
    if (do_rst) begin
      memq.delete();
      buffered = 0;
      epoch++;
      exp_req  = RESET_PC;
      exp_out  = RESET_PC;
      last_due = cyc;
    end else begin
      if (resp_now) begin
        m = memq.pop_front();
        if (m.epoch == epoch && !do_redir) buffered++;
      end
      if (do_redir) begin
        epoch++;
        buffered = 0;
        exp_req  = rpc & ~32'd3;
        exp_out  = exp_req;
      end else begin
        if (s_pop) begin
          buffered--;
          exp_out += 32'd4;
        end
        if (s_acc) begin
          lat = int'($urandom_range(lat_max, lat_min));
          due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
          last_due = due;
          memq.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
          exp_req += 32'd4;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; epoch = 0; buffered = 0; last_due = 0;
    exp_req = RESET_PC; exp_out = RESET_PC;
    rdy_pct = 100; ordy_pct = 100; lat_min = 1; lat_max = 1;
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset, wrap of the PC past the top of memory, first-valid latency.
    repeat (2) step(1'b1, 1'b0, 32'd0);
    first = -1; n_acc = 0;
    for (int i = 0; i < 3; i++) acc_addr[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (s_acc && n_acc < 3) begin
        acc_addr[n_acc] = s_req_addr;
        n_acc++;
      end
      if (s_out_valid && first < 0) first = i;
    end
    check_eq("first_valid_cycle", first, 32'd2);
    check_eq("wrap_addr0", acc_addr[0], 32'hFFFF_FFF8);
    check_eq("wrap_addr1", acc_addr[1], 32'hFFFF_FFFC);
    check_eq("wrap_addr2", acc_addr[2], 32'h0000_0000);

    // Decoder stalled: credit limit caps accepted requests, head held.
    step(1'b1, 1'b0, 32'd0);
    ordy_pct = 0; n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (s_acc) n_acc++;
    end
    check_eq("stall_accepts", n_acc, DEPTH);
    check_eq("stall_req_valid", 32'(s_req_valid), 32'd0);
    check_eq("stall_head_pc", s_out_pc, RESET_PC);
    ordy_pct = 100;
    repeat (10) step(1'b0, 1'b0, 32'd0);

    // Redirect with two requests in flight at latency 3.
    step(1'b1, 1'b0, 32'd0);
    lat_min = 3; lat_max = 3;
    repeat (2) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0100);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (s_out_valid && found == 0) begin
        found = 1;
        check_eq("post_redirect_pc", s_out_pc, 32'h0000_0100);
      end
    end
    check_eq("post_redirect_seen", found, 32'd1);

    // Unaligned redirect target is forced to a word boundary.
    step(1'b0, 1'b1, 32'h0000_0203);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (s_acc && found == 0) begin
        found = 1;
        check_eq("aligned_redirect_addr", s_req_addr, 32'h0000_0200);
      end
    end
    check_eq("aligned_redirect_seen", found, 32'd1);

    // Reset with an entry buffered and a request outstanding.
    step(1'b1, 1'b0, 32'd0);
    ordy_pct = 0;
    repeat (4) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check_eq("after_rst_out_valid", 32'(s_out_valid), 32'd0);
    check_eq("after_rst_req_valid", 32'(s_req_valid), 32'd1);
    check_eq("after_rst_req_addr", s_req_addr, RESET_PC);

    // Redirects around an arriving response, then truly back-to-back.
    ordy_pct = 100; lat_min = 2; lat_max = 2;
    step(1'b1, 1'b0, 32'd0);
    repeat (2) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0400);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0800);
    repeat (3) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0900);
    step(1'b0, 1'b1, 32'h0000_0A00);
    repeat (15) step(1'b0, 1'b0, 32'd0);

    // Randomized traffic, latency, backpressure, redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        lat_min  = 1;
        lat_max  = 1 + int'($urandom_range(3));
        rdy_pct  = 50 + int'($urandom_range(50));
        ordy_pct = 20 + int'($urandom_range(80));
      end
      r = int'($urandom_range(999));
      if (r < 3) step(1'b1, 1'b0, 32'd0);
      else if (r < 40) step(1'b0, 1'b1, $urandom());
      else step(1'b0, 1'b0, 32'd0);
    end
    repeat (10) step(1'b0, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
